// File: rtl/start_bit_detect.sv
// UART receive front end: synchronizes the serial line, qualifies a start bit
// by counting OVERSAMPLE/2 consecutive low samples, and holds recvStart until charRec.
module start_bit_detect #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic serialIn,
  input  logic charRec,
  output logic recvStart
);

  localparam int HALF = OVERSAMPLE / 2;
  localparam int CW   = $clog2(HALF) + 1;
  localparam logic [CW-1:0] LAST_LOW = CW'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    VERIFY  = 2'b01,
    RECEIVE = 2'b10
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_armed;
  logic                   r_recv;

  logic w_s;
  logic w_s_valid;

  assign w_s       = r_sync[SYNC_STAGES-1];
  // The reset value of the synchronizer is not a real line sample, so it must
  // not arm the detector; r_fill marks when s carries a sample taken after reset.
  assign w_s_valid = r_fill[SYNC_STAGES-1];
  assign recvStart = r_recv;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= '1;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], serialIn};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_recv  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_s && w_s_valid) begin
            r_armed <= 1'b1;
          end else if (!w_s && r_armed) begin
            r_state <= VERIFY;
            r_cnt   <= CW'(1);
          end
        end
        VERIFY: begin
          if (w_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == LAST_LOW) begin
            r_state <= RECEIVE;
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_recv  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RECEIVE: begin
          if (charRec) begin
            r_state <= IDLE;
            r_recv  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_armed <= 1'b0;
          r_recv  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_start_bit_detect.sv
// Bench for start_bit_detect: a default (OVERSAMPLE=16) and an OVERSAMPLE=4 instance
// checked against a run-length reference model and fixed timing expectations.
module tb_start_bit_detect;

  localparam int SYNC = 2;

  typedef struct packed {
    logic            rx;
    logic            armed;
    logic [7:0]      run;
    logic [7:0]      fill;
    logic [SYNC-1:0] dly;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ser16 = 1'b1;
  logic crec16 = 1'b0;
  logic ser4 = 1'b1;
  logic crec4 = 1'b0;
  logic rs16;
  logic rs4;
  logic sq_run = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  mdl_t m16 = '0;
  mdl_t m4  = '0;

  always #5 clk = ~clk;

  start_bit_detect #(.OVERSAMPLE(16), .SYNC_STAGES(SYNC)) dut16 (
    .clk(clk), .rst(rst), .serialIn(ser16), .charRec(crec16), .recvStart(rs16)
  );

  start_bit_detect #(.OVERSAMPLE(4), .SYNC_STAGES(SYNC)) dut4 (
    .clk(clk), .rst(rst), .serialIn(ser4), .charRec(crec4), .recvStart(rs4)
  );

  // Line value seen by the detector lags the pin by SYNC clocks; a reception starts
  // after `half` consecutive low samples preceded by a genuine high sample.
  function automatic mdl_t step(mdl_t m, logic rst_n, logic pin, logic crec, int half);
    logic s;
    logic s_ok;
    if (!rst_n) begin
      m = '0;
      m.dly = '1;
      return m;
    end
    s = m.dly[SYNC-1];
    s_ok = (int'(m.fill) >= SYNC);
    m.dly = {m.dly[SYNC-2:0], pin};
    if (int'(m.fill) < SYNC) m.fill = m.fill + 8'd1;
    if (m.rx) begin
      if (crec) m.rx = 1'b0;
    end else if (s && s_ok) begin
      m.armed = 1'b1;
      m.run = '0;
    end else if (!s && m.armed) begin
      m.run = m.run + 8'd1;
      if (int'(m.run) == half) begin
        m.rx = 1'b1;
        m.armed = 1'b0;
        m.run = '0;
      end
    end
    return m;
  endfunction

  always @(posedge clk) begin
    m16 = step(m16, rst, ser16, crec16, 8);
    m4  = step(m4, rst, ser4, crec4, 2);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; ser16 = 1'b1; crec16 = 1'b0; ser4 = 1'b1; crec4 = 1'b0;
    cyc(3);
    n_tests++;
    if (rs16 !== 1'b0 || rs4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: recvStart16=%0b recvStart4=%0b expected 0/0", rs16, rs4);
    end
    rst = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      cyc(1);
      n_tests++;
      if (rs16 !== 1'b0 || rs4 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle_high c%0d: recvStart16=%0b recvStart4=%0b expected 0/0", j, rs16, rs4);
      end
    end
  endtask

  task automatic test_stuck_low;
    ser16 = 1'b0; ser4 = 1'b0; rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      cyc(1);
      n_tests++;
      if (rs16 !== 1'b0 || rs4 !== 1'b0) begin
        n_fail++;
        $display("FAIL stuck_low c%0d: recvStart16=%0b recvStart4=%0b expected 0/0", j, rs16, rs4);
      end
    end
    ser16 = 1'b1;
    cyc(2);
    ser16 = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      cyc(1);
      n_tests++;
      if (rs16 !== (j >= 10)) begin
        n_fail++;
        $display("FAIL stuck_low_rise c%0d: recvStart=%0b expected=%0b", j, rs16, (j >= 10));
      end
    end
    crec16 = 1'b1;
    cyc(1);
    crec16 = 1'b0;
    n_tests++;
    if (rs16 !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_low_charrec: recvStart=%0b expected=0", rs16);
    end
    ser16 = 1'b1; ser4 = 1'b1;
    cyc(3);
  endtask

  task automatic test_valid_start;
    logic exp;
    ser16 = 1'b1;
    cyc(20);
    ser16 = 1'b0;
    for (int j = 1; j <= 60; j++) begin
      cyc(1);
      exp = (j >= 10);
      n_tests++;
      if (rs16 !== exp || rs16 !== m16.rx) begin
        n_fail++;
        $display("FAIL valid_start c%0d: recvStart=%0b expected=%0b model=%0b", j, rs16, exp, m16.rx);
      end
      crec16 = (j == 9);
      if (j >= 16) ser16 = 1'($urandom_range(0, 1));
    end
    crec16 = 1'b1;
    cyc(1);
    crec16 = 1'b0;
    ser16 = 1'b1;
    n_tests++;
    if (rs16 !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_charrec_clear: recvStart=%0b expected=0", rs16);
    end
    for (int j = 1; j <= 5; j++) begin
      cyc(1);
      n_tests++;
      if (rs16 !== 1'b0) begin
        n_fail++;
        $display("FAIL valid_after_clear c%0d: recvStart=%0b expected=0", j, rs16);
      end
    end
  endtask

  task automatic test_glitch;
    int widths[3] = '{1, 4, 7};
    foreach (widths[k]) begin
      ser16 = 1'b1;
      cyc(6);
      ser16 = 1'b0;
      for (int j = 1; j <= widths[k] + 20; j++) begin
        cyc(1);
        if (j == widths[k]) ser16 = 1'b1;
        n_tests++;
        if (rs16 !== 1'b0 || rs16 !== m16.rx) begin
          n_fail++;
          $display("FAIL glitch_w%0d c%0d: recvStart=%0b expected=0 model=%0b", widths[k], j, rs16, m16.rx);
        end
      end
    end
    ser16 = 1'b1;
    cyc(6);
    ser16 = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      cyc(1);
      if (j == 8) ser16 = 1'b1;
      n_tests++;
      if (rs16 !== (j >= 10)) begin
        n_fail++;
        $display("FAIL glitch_w8 c%0d: recvStart=%0b expected=%0b", j, rs16, (j >= 10));
      end
    end
    crec16 = 1'b1;
    cyc(1);
    crec16 = 1'b0;
    n_tests++;
    if (rs16 !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_w8_clear: recvStart=%0b expected=0", rs16);
    end
  endtask

  task automatic test_square;
    logic seen4 = 1'b0;
    ser16 = 1'b1; ser4 = 1'b1;
    cyc(5);
    @(posedge clk);
    #2;
    sq_run = 1'b1;
    fork
      begin
        while (sq_run) begin
          ser16 = ~ser16;
          ser4 = ~ser4;
          #25;
        end
      end
    join_none
    for (int j = 1; j <= 200; j++) begin
      cyc(1);
      seen4 |= rs4;
      n_tests++;
      if (rs16 !== 1'b0 || rs4 !== m4.rx) begin
        n_fail++;
        $display("FAIL square c%0d: recvStart16=%0b expected=0 recvStart4=%0b expected=%0b", j, rs16, rs4, m4.rx);
      end
    end
    n_tests++;
    if (seen4 !== 1'b1 || rs4 !== 1'b1) begin
      n_fail++;
      $display("FAIL square_os4_assert: seen=%0b now=%0b expected 1/1", seen4, rs4);
    end
    crec4 = 1'b1;
    cyc(1);
    crec4 = 1'b0;
    n_tests++;
    if (rs4 !== 1'b0) begin
      n_fail++;
      $display("FAIL square_os4_clear: recvStart4=%0b expected=0", rs4);
    end
    sq_run = 1'b0;
    #30;
    @(negedge clk);
    ser16 = 1'b1; ser4 = 1'b1;
    cyc(3);
  endtask

  task automatic test_reset_mid_rx;
    ser16 = 1'b1;
    cyc(5);
    ser16 = 1'b0;
    cyc(12);
    n_tests++;
    if (rs16 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rx_pre: recvStart=%0b expected=1", rs16);
    end
    rst = 1'b0;
    crec16 = 1'b1;
    cyc(1);
    rst = 1'b1;
    crec16 = 1'b0;
    n_tests++;
    if (rs16 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rx_abort: recvStart=%0b expected=0", rs16);
    end
    for (int j = 1; j <= 30; j++) begin
      cyc(1);
      n_tests++;
      if (rs16 !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_rx_low_hold c%0d: recvStart=%0b expected=0", j, rs16);
      end
    end
    ser16 = 1'b1;
    cyc(2);
    ser16 = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      cyc(1);
      n_tests++;
      if (rs16 !== (j >= 10)) begin
        n_fail++;
        $display("FAIL mid_rx_restart c%0d: recvStart=%0b expected=%0b", j, rs16, (j >= 10));
      end
    end
    crec16 = 1'b1;
    cyc(1);
    crec16 = 1'b0;
    ser16 = 1'b1;
    cyc(3);
  endtask

  task automatic test_random;
    int hold16 = 0;
    int hold4 = 0;
    for (int j = 1; j <= 3000; j++) begin
      if (hold16 == 0) begin
        ser16 = ~ser16;
        hold16 = $urandom_range(1, 20);
      end
      if (hold4 == 0) begin
        ser4 = ~ser4;
        hold4 = $urandom_range(1, 5);
      end
      hold16--;
      hold4--;
      crec16 = ($urandom_range(0, 15) == 0);
      crec4 = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 499) != 0);
      cyc(1);
      n_tests++;
      if (rs16 !== m16.rx || rs4 !== m4.rx) begin
        n_fail++;
        $display("FAIL random c%0d: recvStart16=%0b expected=%0b recvStart4=%0b expected=%0b", j, rs16, m16.rx, rs4, m4.rx);
      end
    end
    rst = 1'b1; crec16 = 1'b0; crec4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stuck_low();
    test_valid_start();
    test_glitch();
    test_square();
    test_reset_mid_rx();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/start_bit_detect.md
Name: start_bit_detect

Overview:
- UART receive front end: watches the asynchronous serial line and qualifies a genuine start bit.
- Asserts recvStart for the whole duration of a character reception; charRec from the downstream bit-sampler/shift-register ends it.
- Clock runs at OVERSAMPLE × baud rate.
- Sits between the raw serial input pin and the receive datapath of the chat link.

Parameters:
- OVERSAMPLE, 16: clock cycles per bit period; must be even and ≥4.
- SYNC_STAGES, 2: flip-flop stages in the serialIn synchronizer; ≥2.

Ports:
- clk  input  1  system clock (OVERSAMPLE × baud).
- rst  input  1  reset; one clock, reset is synchronous and active-low.
- serialIn  input  1  asynchronous serial line; idles high, start bit is low.
- charRec  input  1  from receive datapath; high for ≥1 cycle when a full character (through stop bit) has been captured.
- recvStart  output  1  registered; high while a qualified character reception is in progress.

Behaviour:
- Reset:
  - rst sampled low at a rising clk edge forces state IDLE, recvStart=0, verify counter=0, all synchronizer flops=1 and armed=0.
  - Reset has priority over all other inputs and aborts any reception in progress.
- Synchronizer:
  - serialIn passes through SYNC_STAGES flops; the last stage is "s".
  - All decisions use s only.
  - Latency: SYNC_STAGES cycles from a pin change to s.
- armed flag:
  - Set on any cycle with s=1 in IDLE.
  - Cleared by reset and on entry to RECEIVE.
  - A start is only accepted when armed=1, i.e. a high-to-low transition is required; a line stuck low after reset or after a character never triggers.
- States: IDLE, VERIFY, RECEIVE (2-bit encoding; illegal encoding recovers to IDLE).
- IDLE:
  - If s=0 and armed=1, go to VERIFY with counter=1; this is low sample #1.
  - charRec is ignored.
- VERIFY:
  - Each cycle with s=0 increments the counter.
  - If s=0 and counter==OVERSAMPLE/2−1, go to RECEIVE.
  - If s=1 on any cycle, the start is rejected as a glitch: go to IDLE with counter=0. armed stays 1 because s=1.
  - charRec is ignored.
- RECEIVE:
  - recvStart=1 (registered; first high cycle is the cycle after the OVERSAMPLE/2-th consecutive low sample of s).
  - Remain in RECEIVE regardless of serialIn until charRec=1 is sampled.
  - Then go to IDLE; recvStart=0 from the next cycle.
- Qualification rule: exactly OVERSAMPLE/2 consecutive low samples of s, counting the IDLE detection sample, are required. With the default this is 8 samples, i.e. mid-start-bit.
- Total latency from the pin falling edge to recvStart=1 is SYNC_STAGES + OVERSAMPLE/2 cycles (10 with defaults).
- Simultaneous events:
  - charRec=1 on the same cycle as entry into RECEIVE has no effect; it is only honoured while already in RECEIVE.
  - Reset together with charRec: reset wins.
- Back-to-back characters:
  - After charRec the line must be seen high (s=1) in IDLE before the next start is accepted.
  - The minimum gap is therefore 1 cycle of s=1.
- recvStart is glitch-free: it is driven directly from a flop.

Test Plan:
- Reset with serialIn=1 and charRec=0, then release: recvStart=0 and state IDLE; it stays 0 indefinitely while serialIn stays 1.
- Hold serialIn=0 before and through reset release, with no prior high: recvStart stays 0 for ≥40 cycles. Then drive serialIn 1 for 2 cycles and back to 0: recvStart rises exactly 10 cycles after the falling edge.
- Valid start (defaults) from idle-high: drive serialIn low for 16 cycles then high; recvStart=1 at cycle 10 after the edge and stays 1 through arbitrary data toggling. Pulse charRec for 1 cycle: recvStart=0 on the following cycle.
- Glitch rejection: low pulses of 1, 4 and 7 cycles (post-sync width) each leave recvStart=0. An 8-cycle low pulse asserts recvStart.
- Square-wave line (period 50 time units, toggling every half period, much shorter than a bit at OVERSAMPLE=16): recvStart never asserts. With OVERSAMPLE=4 and a half-period of ≥2 clocks: recvStart asserts, then deasserts one cycle after charRec=1.
- Reset mid-reception: with recvStart=1, assert rst low for 1 cycle: recvStart=0 on the next cycle, and a new start needs a fresh high then low on the line.
